// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches 32-bit words from
// instruction memory over a req/ack handshake and presents one instruction at
// a time to the decoder over a valid/ready handshake.
//
// Build option FETCH_MISALIGN_CHECK_EN: when defined, a redirect to a
// non-word-aligned target raises a sticky Fetch_fault and parks the unit in
// FAULT until reset. When undefined, the low two bits of the target are
// cleared on load.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset; first request is issued on the next edge
// REQ   | request outstanding, waiting for imem_ack
// HOLD  | instruction held on Instr, waiting for Instr_ready
// FAULT | misaligned redirect seen; idle until reset (option only)

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    input  logic        Instr_ready,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        Fetch_fault
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] S_FAULT = 2'd3;
`endif

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_d;
    logic        req_d;
    logic [31:0] addr_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        kill_q;
    logic        kill_d;
    logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fault_d;
    logic        redirect_misaligned;
`endif

    // Only the held PC feeds the incrementer; wraps modulo 2^32.
    assign PCPlus4 = PC + 32'd4;

    // Targets are always loaded word-aligned; with the check enabled a
    // misaligned target never reaches the PC because it diverts to FAULT.
    assign redirect_target = redirect_pc & ~32'h0000_0003;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_misaligned = |redirect_pc[1:0];
`endif

    // Next-state and next-output computation; redirect outranks PC+4 everywhere.
    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        req_d   = imem_req;
        addr_d  = imem_addr;
        instr_d = Instr;
        valid_d = Instr_valid;
        kill_d  = kill_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d = Fetch_fault;
`endif

        case (state_q)
            S_IDLE: begin
                req_d   = 1'b1;
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d   = redirect_target;
                    addr_d = redirect_target;
                end else begin
                    addr_d = PC;
                end
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_ack) begin
                        // Handshake ends this edge, so the reissue can go
                        // straight to the new target without a kill.
                        addr_d = redirect_target;
                        kill_d = 1'b0;
                    end else begin
                        // Address must not move mid-handshake; mark the
                        // pending response stale instead.
                        kill_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        addr_d = PC;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    addr_d  = redirect_target;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (Instr_ready) begin
                    pc_d    = PCPlus4;
                    addr_d  = PCPlus4;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end

`ifdef FETCH_MISALIGN_CHECK_EN
            S_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
`endif

            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_CHECK_EN
        // A misaligned target overrides everything above: PC is kept, any
        // in-flight request is abandoned and the unit stops.
        if ((state_q != S_FAULT) && redirect_valid && redirect_misaligned) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
            pc_d    = PC;
            addr_d  = imem_addr;
            req_d   = 1'b0;
            valid_d = 1'b0;
            kill_d  = 1'b0;
        end
`endif
    end

    // State and all registered outputs; reset drops imem_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            PC          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            Instr       <= 32'h0000_0000;
            Instr_valid <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            PC          <= pc_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            Instr       <= instr_d;
            Instr_valid <= valid_d;
            kill_q      <= kill_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Fetch_fault <= 1'b0;
        end else begin
            Fetch_fault <= fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. Inputs change 1ns after the rising edge; the
// retire scoreboard samples on the falling edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic        Instr_ready;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        Fetch_fault;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int wait_states = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .Instr          (Instr),
        .Instr_valid    (Instr_valid),
        .Instr_ready    (Instr_ready),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .Fetch_fault    (Fetch_fault)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return a ^ 32'h8C00_0000;
    endfunction

    function automatic void push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endfunction

    // Memory model with programmable wait states plus address-hold check.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          wcnt = 0;
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    end
    always begin
        @(posedge clk);
        #1;
        if (!rst_n || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end else begin
            if (prev_req && !prev_ack) begin
                n_checks++;
                if (imem_addr !== prev_addr)
                    $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, prev_addr);
                else n_pass++;
            end
            if (imem_ack) wcnt = 0;
            imem_ack   = (wcnt >= wait_states);
            imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
            wcnt++;
        end
        prev_req  = rst_n && imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    end

    // Retire scoreboard: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (rst_n && Instr_valid && Instr_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL retire_unexpected: PC=%h Instr=%h, required no retire", PC, Instr);
            end else begin
                mon_e = exp_q.pop_front();
                if (PC !== mon_e.pc || Instr !== mon_e.instr || PCPlus4 !== mon_e.pc + 32'd4)
                    $display("FAIL retire: PC=%h Instr=%h PCPlus4=%h required PC=%h Instr=%h PCPlus4=%h",
                             PC, Instr, PCPlus4, mon_e.pc, mon_e.instr, mon_e.pc + 32'd4);
                else n_pass++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    task automatic apply_reset();
        rst_n          = 1'b0;
        Instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: %b required 0", imem_req); else n_pass++;
        n_checks++; if (Instr_valid !== 1'b0) $display("FAIL reset_valid: %b required 0", Instr_valid); else n_pass++;
        n_checks++; if (PC !== 32'h0) $display("FAIL reset_pc: %h required 0", PC); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: %h required 0", imem_addr); else n_pass++;
        n_checks++; if (Instr !== 32'h0) $display("FAIL reset_instr: %h required 0", Instr); else n_pass++;
        n_checks++; if (PCPlus4 !== 32'h4) $display("FAIL reset_pcplus4: %h required 4", PCPlus4); else n_pass++;
    endtask

    task automatic test_first_fetch();
        int nvalid = 0;
        wait_states = 0;
        apply_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        Instr_ready = 1'b1;
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (Instr_valid) nvalid++;
            if (c == 1) begin
                n_checks++;
                if (Instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
                    $display("FAIL first_req: valid=%b req=%b addr=%h required 0 1 0", Instr_valid, imem_req, imem_addr);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (Instr_valid !== 1'b1 || Instr !== 32'h2008_0005 || PC !== 32'h0 || PCPlus4 !== 32'h4)
                    $display("FAIL first_valid: valid=%b Instr=%h PC=%h PCPlus4=%h required 1 20080005 0 4",
                             Instr_valid, Instr, PC, PCPlus4);
                else n_pass++;
            end
            if (c == 3) begin
                n_checks++;
                if (Instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4)
                    $display("FAIL second_req: valid=%b req=%b addr=%h required 0 1 4", Instr_valid, imem_req, imem_addr);
                else n_pass++;
            end
        end
        n_checks++; if (nvalid != 4) $display("FAIL throughput: %0d valid cycles in 8, required 4", nvalid); else n_pass++;
        step();
        Instr_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL first_drain: %0d left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wait_states();
        int bad = 0;
        int n = 0;
        wait_states = 3;
        apply_reset();
        push_exp(32'h0); push_exp(32'h4);
        rst_n = 1'b1;
        step();
        for (int c = 2; c <= 4; c++) begin
            step();
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || Instr_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL ws_wait: %0d bad wait cycles, required 0", bad); else n_pass++;
        step();
        n_checks++;
        if (Instr_valid !== 1'b1 || Instr !== mem_word(32'h0) || PC !== 32'h0)
            $display("FAIL ws_valid: valid=%b Instr=%h PC=%h required 1 %h 0", Instr_valid, Instr, PC, mem_word(32'h0));
        else n_pass++;
        bad = 0;
        for (int c = 6; c <= 9; c++) begin
            step();
            if (Instr_valid !== 1'b1 || Instr !== mem_word(32'h0) || PC !== 32'h0 || imem_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL ws_hold: %0d unstable cycles, required 0", bad); else n_pass++;
        Instr_ready = 1'b1;
        step();
        n_checks++;
        if (Instr_valid !== 1'b0 || PC !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h4)
            $display("FAIL ws_advance: valid=%b PC=%h req=%b addr=%h required 0 4 1 4", Instr_valid, PC, imem_req, imem_addr);
        else n_pass++;
        while (exp_q.size() != 0 && n < 60) begin step(); n++; end
        Instr_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL ws_drain: %0d left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        int n = 0;
        wait_states = 0;
        apply_reset();
        push_exp(32'h100);
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || PC !== 32'h40)
            $display("FAIL idle_redirect: req=%b addr=%h PC=%h required 1 40 40", imem_req, imem_addr, PC);
        else n_pass++;
        step();
        n_checks++;
        if (Instr_valid !== 1'b1 || PC !== 32'h40 || Instr !== mem_word(32'h40))
            $display("FAIL hold_40: valid=%b PC=%h Instr=%h required 1 40 %h", Instr_valid, PC, Instr, mem_word(32'h40));
        else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (Instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || PC !== 32'h100)
            $display("FAIL hold_redirect: valid=%b req=%b addr=%h PC=%h required 0 1 100 100",
                     Instr_valid, imem_req, imem_addr, PC);
        else n_pass++;
        Instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin step(); n++; end
        Instr_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL hold_drain: %0d left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_kill();
        int n = 0;
        wait_states = 3;
        apply_reset();
        push_exp(32'h200);
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8)
            $display("FAIL kill_req8: req=%b addr=%h required 1 8", imem_req, imem_addr);
        else n_pass++;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || PC !== 32'h200 || Instr_valid !== 1'b0)
            $display("FAIL kill_pending: req=%b addr=%h PC=%h valid=%b required 1 8 200 0",
                     imem_req, imem_addr, PC, Instr_valid);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || Instr_valid !== 1'b0)
            $display("FAIL kill_reissue: req=%b addr=%h valid=%b required 1 200 0", imem_req, imem_addr, Instr_valid);
        else n_pass++;
        Instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin step(); n++; end
        Instr_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL kill_drain: %0d left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_on_ack();
        int n = 0;
        wait_states = 0;
        apply_reset();
        push_exp(32'h500); push_exp(32'h504);
        Instr_ready = 1'b1;
        rst_n = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (Instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h500 || PC !== 32'h500)
            $display("FAIL ack_redirect: valid=%b req=%b addr=%h PC=%h required 0 1 500 500",
                     Instr_valid, imem_req, imem_addr, PC);
        else n_pass++;
        step();
        n_checks++;
        if (Instr_valid !== 1'b1 || PC !== 32'h500)
            $display("FAIL ack_no_kill: valid=%b PC=%h required 1 500", Instr_valid, PC);
        else n_pass++;
        while (exp_q.size() != 0 && n < 60) begin step(); n++; end
        Instr_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL ack_drain: %0d left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        wait_states = 0;
        apply_reset();
        push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (Instr_valid !== 1'b1 || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0)
            $display("FAIL wrap_hold: valid=%b PC=%h PCPlus4=%h required 1 fffffffc 0", Instr_valid, PC, PCPlus4);
        else n_pass++;
        Instr_ready = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL wrap_addr: req=%b addr=%h required 1 0", imem_req, imem_addr);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || exp_q.size() != 0)
            $display("FAIL wrap_next: req=%b addr=%h left=%0d required 1 4 0", imem_req, imem_addr, exp_q.size());
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || PC !== 32'h0 || Instr_valid !== 1'b0)
            $display("FAIL async_reset: req=%b PC=%h valid=%b required 0 0 0", imem_req, PC, Instr_valid);
        else n_pass++;
        Instr_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        wait_states = 0;
        apply_reset();
`ifndef FETCH_MISALIGN_CHECK_EN
        push_exp(32'h100);
`endif
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        begin
            int bad = 0;
            n_checks++;
            if (Fetch_fault !== 1'b1 || imem_req !== 1'b0 || PC !== 32'h0)
                $display("FAIL fault_set: fault=%b req=%b PC=%h required 1 0 0", Fetch_fault, imem_req, PC);
            else n_pass++;
            Instr_ready = 1'b1;
            for (int c = 0; c < 10; c++) begin
                step();
                if (imem_req !== 1'b0 || Instr_valid !== 1'b0 || Fetch_fault !== 1'b1) bad++;
            end
            n_checks++; if (bad != 0) $display("FAIL fault_park: %0d bad cycles, required 0", bad); else n_pass++;
            Instr_ready = 1'b0;
        end
`else
        begin
            int n = 0;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 || PC !== 32'h100)
                $display("FAIL misalign_clear: req=%b addr=%h PC=%h required 1 100 100", imem_req, imem_addr, PC);
            else n_pass++;
            Instr_ready = 1'b1;
            while (exp_q.size() != 0 && n < 60) begin step(); n++; end
            Instr_ready = 1'b0;
            n_checks++; if (exp_q.size() != 0) $display("FAIL misalign_drain: %0d left, required 0", exp_q.size()); else n_pass++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_redirect_hold();
        test_redirect_kill();
        test_redirect_on_ack();
        test_wrap_and_reset();
        test_misaligned();
        apply_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
